smm_cif_0_2_sdiv_32s_16s_seq: RTL and testbench

//   Sequential signed divider: the inverse of the 16sx16s->32 product path. Divides a

---
 rtl/smm_cif_0_2_sdiv_32s_16s_seq.sv | 141 ++++++++++++++
 tb/tb_smm_cif_0_2_sdiv_32s_16s_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/smm_cif_0_2_sdiv_32s_16s_seq.sv
// Sequential signed restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Quotient truncates toward zero, remainder takes the dividend's sign, divide-by-zero is flagged.
module smm_cif_0_2_sdiv_32s_16s_seq #(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    // One extra magnitude bit keeps -2^(W-1) exact; CALC walks all XW bits of it.
    localparam int XW    = DIVIDEND_W + 1;
    localparam int CNT_W = $clog2(XW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [XW-1:0]        quo_q, quo_d;
    logic [XW-1:0]        rem_q, rem_d;
    logic [XW-1:0]        dsr_q, dsr_d;
    logic [DIVISOR_W-1:0] dvd_lo_q, dvd_lo_d;
    logic                 sign_q_q, sign_q_d;
    logic                 sign_r_q, sign_r_d;
    logic                 dbz_q, dbz_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  div_by_zero_q, div_by_zero_d;

    logic [XW-1:0] dvd_sx, dsr_sx, rem_sh;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        dsr_d         = dsr_q;
        dvd_lo_d      = dvd_lo_q;
        sign_q_d      = sign_q_q;
        sign_r_d      = sign_r_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        dvd_sx        = {dividend[DIVIDEND_W-1], dividend};
        dsr_sx        = {{(XW-DIVISOR_W){divisor[DIVISOR_W-1]}}, divisor};
        rem_sh        = {rem_q[XW-2:0], quo_q[XW-1]};

        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    quo_d    = dividend[DIVIDEND_W-1] ? (~dvd_sx) + XW'(1) : dvd_sx;
                    dsr_d    = divisor[DIVISOR_W-1] ? (~dsr_sx) + XW'(1) : dsr_sx;
                    rem_d    = '0;
                    cnt_d    = '0;
                    dvd_lo_d = dividend[DIVISOR_W-1:0];
                    sign_q_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                    sign_r_d = dividend[DIVIDEND_W-1];
                    dbz_d    = (divisor == '0);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (rem_sh >= dsr_q) begin
                    rem_d = rem_sh - dsr_q;
                    quo_d = {quo_q[XW-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[XW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XW - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_lo_q;
                end else begin
                    // Truncation to W bits gives the -2^(W-1)/-1 wrap for free.
                    quotient_d  = sign_q_q ? DIVIDEND_W'((~quo_q) + XW'(1)) : DIVIDEND_W'(quo_q);
                    remainder_d = sign_r_q ? DIVISOR_W'((~rem_q) + XW'(1)) : DIVISOR_W'(rem_q);
                end
                div_by_zero_d = dbz_q;
                state_d       = S_DONE;
            end
            default: begin
                if (dout_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dsr_q         <= '0;
            dvd_lo_q      <= '0;
            sign_q_q      <= 1'b0;
            sign_r_q      <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            dsr_q         <= dsr_d;
            dvd_lo_q      <= dvd_lo_d;
            sign_q_q      <= sign_q_d;
            sign_r_q      <= sign_r_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign din_ready   = (state_q == S_IDLE);
    assign dout_valid  = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_smm_cif_0_2_sdiv_32s_16s_seq.sv
// Directed bench for the sequential signed divider: values, latency, back-pressure, reset.
module tb_smm_cif_0_2_sdiv_32s_16s_seq;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total;
    int bad;

    smm_cif_0_2_sdiv_32s_16s_seq #(.ID(1), .DIVIDEND_W(32), .DIVISOR_W(16)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Accept one operand pair and wait for dout_valid; caller is #1 after a rising edge.
    task automatic start_and_wait(input logic [31:0] a, input logic [15:0] b,
                                  input string name, output int lat);
        total++;
        if (din_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s din_ready before accept: got %b want 1", name, din_ready);
        end
        din_valid = 1'b1;
        dividend  = a;
        divisor   = b;
        @(posedge ap_clk);
        #1;
        din_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge ap_clk);
            #1;
            if (dout_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                           input logic [31:0] eq, input logic [15:0] er, input logic ez,
                           input string name);
        int lat;
        start_and_wait(a, b, name, lat);
        total++;
        if (lat !== 34) begin
            bad++;
            $display("FAIL %s latency: got %0d want 34", name, lat);
        end
        total++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            bad++;
            $display("FAIL %s result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     name, quotient, remainder, div_by_zero, eq, er, ez);
        end
        dout_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        dout_ready = 1'b0;
        total++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s consume: got valid=%b ready=%b want 0 1", name, dout_valid, din_ready);
        end
    endtask

    task automatic test_reset();
        ap_rst_n   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        dividend   = '0;
        divisor    = '0;
        #12;
        total++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || quotient !== 32'd0 ||
            remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0 0 0",
                     din_ready, dout_valid, quotient, remainder, div_by_zero);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_basic();
        run_div(32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, "1000/7");
    endtask

    task automatic test_signs();
        run_div(-32'sd1000, 16'd7, -32'sd142, -16'sd6, 1'b0, "-1000/7");
        run_div(32'd1000, -16'sd7, -32'sd142, 16'd6, 1'b0, "1000/-7");
        run_div(-32'sd1000, -16'sd7, 32'd142, -16'sd6, 1'b0, "-1000/-7");
        run_div(-32'sd7, 16'd1000, 32'd0, -16'sd7, 1'b0, "-7/1000");
    endtask

    task automatic test_extremes();
        run_div(32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0, "min/-1");
        run_div(32'h8000_0000, 16'h8000, 32'd65536, 16'd0, 1'b0, "min/-32768");
        run_div(32'd32767, 16'd32767, 32'd1, 16'd0, 1'b0, "32767/32767");
        run_div(32'h8000_0000, 16'd1, 32'h8000_0000, 16'd0, 1'b0, "min/1");
    endtask

    task automatic test_div_zero();
        run_div(32'd12345, 16'd0, 32'hFFFF_FFFF, 16'h3039, 1'b1, "12345/0");
        run_div(32'd10, 16'd3, 32'd3, 16'd1, 1'b0, "10/3 after dbz");
    endtask

    task automatic test_back_to_back_pressure();
        int lat;
        start_and_wait(32'd50000, -16'sd300, "bp", lat);
        total++;
        if (lat !== 34 || quotient !== -32'sd166 || remainder !== 16'd200) begin
            bad++;
            $display("FAIL bp first: got lat=%0d q=%h r=%h want 34 %h %h",
                     lat, quotient, remainder, -32'sd166, 16'd200);
        end
        for (int i = 0; i < 10; i++) begin
            din_valid = i[0];
            dividend  = 32'd999;
            divisor   = 16'd9;
            @(posedge ap_clk);
            #1;
            total++;
            if (dout_valid !== 1'b1 || din_ready !== 1'b0 || quotient !== -32'sd166 ||
                remainder !== 16'd200 || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL bp hold %0d: got vld=%b rdy=%b q=%h r=%h", i,
                         dout_valid, din_ready, quotient, remainder);
            end
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        total++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp consume: got vld=%b rdy=%b want 0 1", dout_valid, din_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk);
            #1;
        end
        dout_ready = 1'b0;
        total++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp no_queue: got vld=%b rdy=%b want 0 1", dout_valid, din_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        din_valid = 1'b1;
        dividend  = 32'd123456;
        divisor   = 16'd7;
        @(posedge ap_clk);
        #1;
        din_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge ap_clk);
            #1;
        end
        ap_rst_n = 1'b0;
        #1;
        total++;
        if (quotient !== 32'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0 ||
            dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid outputs: got q=%h r=%h z=%b vld=%b rdy=%b want 0 0 0 0 1",
                     quotient, remainder, div_by_zero, dout_valid, din_ready);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk);
            #1;
            if (dout_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_mid stale: got %0d valid cycles want 0", seen);
        end
        run_div(32'd100, 16'd3, 32'd33, 16'd1, 1'b0, "100/3 after reset");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_div_zero();
        test_back_to_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
